// File: rtl/cart_load_sequencer.sv
// Routes hps_io cart downloads into SDRAM channel 0, strips and parses an A78 header,
// throttles hps_io with ioctl_wait, and passes core cart reads through when idle.
module cart_load_sequencer #(
    parameter int unsigned HDR_LEN      = 128,
    parameter logic [5:0]  CART_INDEX   = 6'd1,
    parameter logic [31:0] DEF_HDR_SIZE = 32'h00008000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    input  logic [24:0] core_addr,
    input  logic        core_rd,
    output logic [24:0] sd_addr,
    output logic [7:0]  sd_din,
    output logic        sd_wr,
    output logic        sd_rd,
    input  logic        sd_busy,
    output logic        cart_is_7800,
    output logic [31:0] hdr_size,
    output logic [15:0] cart_flags,
    output logic [7:0]  cart_region,
    output logic [7:0]  cart_save,
    output logic [7:0]  cart_xm,
    output logic [31:0] cart_size,
    output logic        cart_loaded
);

    localparam logic [24:0] HdrLen = 25'(HDR_LEN);

    typedef enum logic [2:0] {
        StIdle, StProbe, StReplay, StHeader, StStream, StFlush, StFinish
    } state_e;

    state_e      state_q, state_d;
    logic        dl_q;
    logic        wait_q, wait_d;
    logic        pend_q, pend_d, issued_q, issued_d, seen_q, seen_d;
    logic [24:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  buf_q [6];
    logic [7:0]  buf_d [6];
    logic [2:0]  cnt_q, cnt_d, rp_q, rp_d, lim_q, lim_d;
    logic [24:0] last_q, last_d;
    logic        got_q, got_d;
    logic        is7800_q, is7800_d;
    logic [31:0] hsize_q, hsize_d;
    logic [15:0] flags_q, flags_d;
    logic [7:0]  region_q, region_d, save_q, save_d, xm_q, xm_d;
    logic [31:0] size_q, size_d;
    logic        loaded_q, loaded_d;

    logic        dl, dl_rise, accept, wr_done, rd_pass, load_stream, match;
    logic [24:0] offset;
    logic        unused_idx;

    assign unused_idx  = ^ioctl_index[7:6];
    assign dl          = ioctl_download & (ioctl_index[5:0] == CART_INDEX);
    assign dl_rise     = dl & ~dl_q;
    // Strobes arriving while stalled are dropped by hps_io contract.
    assign accept      = ioctl_wr & ~wait_q & dl;
    assign wr_done     = pend_q & issued_q & seen_q & ~sd_busy;
    assign offset      = is7800_q ? HdrLen : 25'd0;
    assign match       = (buf_q[1] == 8'h41) && (buf_q[2] == 8'h54) && (buf_q[3] == 8'h41) &&
                         (buf_q[4] == 8'h52) && (ioctl_dout == 8'h49);

    assign rd_pass     = (state_q == StIdle) & ~dl;
    assign sd_rd       = rd_pass & core_rd;
    assign sd_addr     = rd_pass ? core_addr : wr_addr_q;
    assign sd_din      = wr_data_q;
    assign sd_wr       = pend_q & ~issued_q & ~sd_busy;
    assign ioctl_wait  = wait_q;

    assign cart_is_7800 = is7800_q;
    assign hdr_size     = hsize_q;
    assign cart_flags   = flags_q;
    assign cart_region  = region_q;
    assign cart_save    = save_q;
    assign cart_xm      = xm_q;
    assign cart_size    = size_q;
    assign cart_loaded  = loaded_q;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        pend_d      = pend_q;
        issued_d    = issued_q;
        seen_d      = seen_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        rp_d        = rp_q;
        lim_d       = lim_q;
        last_d      = last_q;
        got_d       = got_q;
        is7800_d    = is7800_q;
        hsize_d     = hsize_q;
        flags_d     = flags_q;
        region_d    = region_q;
        save_d      = save_q;
        xm_d        = xm_q;
        size_d      = size_q;
        loaded_d    = loaded_q;
        load_stream = 1'b0;

        // Write engine: strobe once, then wait for busy to rise and fall.
        if (sd_wr) issued_d = 1'b1;
        if (issued_q && sd_busy) seen_d = 1'b1;
        if (wr_done) begin
            pend_d = 1'b0;
            if (state_q == StStream) wait_d = 1'b0;
        end

        if (dl_rise) begin
            is7800_d = 1'b0;
            hsize_d  = DEF_HDR_SIZE;
            flags_d  = 16'h0000;
            region_d = 8'h00;
            save_d   = 8'h00;
            xm_d     = 8'h00;
            got_d    = 1'b0;
            cnt_d    = 3'd0;
        end

        case (state_q)
            StIdle: begin
                if (dl_rise) state_d = StProbe;
            end
            StProbe: begin
                if (!dl) begin
                    lim_d   = cnt_q;
                    rp_d    = 3'd0;
                    state_d = StFlush;
                end else if (accept) begin
                    buf_d[cnt_q] = ioctl_dout;
                    cnt_d        = cnt_q + 3'd1;
                    last_d       = ioctl_addr;
                    got_d        = 1'b1;
                    if (cnt_q == 3'd5) begin
                        if (match) begin
                            is7800_d = 1'b1;
                            state_d  = StHeader;
                        end else begin
                            lim_d   = 3'd6;
                            rp_d    = 3'd0;
                            wait_d  = 1'b1;
                            state_d = StReplay;
                        end
                    end
                end
            end
            StReplay, StFlush: begin
                if (!pend_q) begin
                    if (rp_q == lim_q) begin
                        wait_d  = 1'b0;
                        state_d = (state_q == StReplay) ? StStream : StFinish;
                    end else begin
                        pend_d    = 1'b1;
                        issued_d  = 1'b0;
                        seen_d    = 1'b0;
                        wr_addr_d = {22'd0, rp_q};
                        wr_data_d = buf_q[rp_q];
                        rp_d      = rp_q + 3'd1;
                    end
                end
            end
            StHeader: begin
                if (!dl) begin
                    state_d = StFinish;
                end else if (accept) begin
                    last_d = ioctl_addr;
                    got_d  = 1'b1;
                    if (ioctl_addr >= HdrLen) begin
                        load_stream = 1'b1;
                        state_d     = StStream;
                    end else begin
                        case (ioctl_addr)
                            25'd49:  hsize_d[31:24] = ioctl_dout;
                            25'd50:  hsize_d[23:16] = ioctl_dout;
                            25'd51:  hsize_d[15:8]  = ioctl_dout;
                            25'd52:  hsize_d[7:0]   = ioctl_dout;
                            25'd53:  flags_d[15:8]  = ioctl_dout;
                            25'd54:  flags_d[7:0]   = ioctl_dout;
                            25'd57:  region_d       = ioctl_dout;
                            25'd58:  save_d         = ioctl_dout;
                            25'd63:  xm_d           = ioctl_dout;
                            default: ;
                        endcase
                    end
                end
            end
            StStream: begin
                if (accept) begin
                    last_d      = ioctl_addr;
                    got_d       = 1'b1;
                    load_stream = 1'b1;
                end else if (!dl && !pend_q) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                size_d   = got_q ? {7'd0, last_q + 25'd1 - offset} : 32'd0;
                loaded_d = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (load_stream) begin
            pend_d    = 1'b1;
            issued_d  = 1'b0;
            seen_d    = 1'b0;
            wait_d    = 1'b1;
            wr_addr_d = ioctl_addr - offset;
            wr_data_d = ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            dl_q      <= 1'b0;
            wait_q    <= 1'b0;
            pend_q    <= 1'b0;
            issued_q  <= 1'b0;
            seen_q    <= 1'b0;
            wr_addr_q <= 25'd0;
            wr_data_q <= 8'h00;
            buf_q     <= '{default: 8'h00};
            cnt_q     <= 3'd0;
            rp_q      <= 3'd0;
            lim_q     <= 3'd0;
            last_q    <= 25'd0;
            got_q     <= 1'b0;
            is7800_q  <= 1'b0;
            hsize_q   <= DEF_HDR_SIZE;
            flags_q   <= 16'h0000;
            region_q  <= 8'h00;
            save_q    <= 8'h00;
            xm_q      <= 8'h00;
            size_q    <= 32'd0;
            loaded_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dl_q      <= dl;
            wait_q    <= wait_d;
            pend_q    <= pend_d;
            issued_q  <= issued_d;
            seen_q    <= seen_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            rp_q      <= rp_d;
            lim_q     <= lim_d;
            last_q    <= last_d;
            got_q     <= got_d;
            is7800_q  <= is7800_d;
            hsize_q   <= hsize_d;
            flags_q   <= flags_d;
            region_q  <= region_d;
            save_q    <= save_d;
            xm_q      <= xm_d;
            size_q    <= size_d;
            loaded_q  <= loaded_d;
        end
    end

endmodule

// File: tb/tb_cart_load_sequencer.sv
// Scoreboard bench: a file-level model predicts every SDRAM write and the final cart fields;
// a monitor pops predicted writes whenever the DUT strobes sd_wr.
module tb_cart_load_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wr = 1'b0;
    logic        ioctl_wait;
    logic [24:0] core_addr = '0;
    logic        core_rd = 1'b0;
    logic [24:0] sd_addr;
    logic [7:0]  sd_din;
    logic        sd_wr, sd_rd, sd_busy;
    logic        cart_is_7800;
    logic [31:0] hdr_size;
    logic [15:0] cart_flags;
    logic [7:0]  cart_region, cart_save, cart_xm;
    logic [31:0] cart_size;
    logic        cart_loaded;

    cart_load_sequencer dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .ioctl_wait(ioctl_wait), .core_addr(core_addr), .core_rd(core_rd),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_wr(sd_wr), .sd_rd(sd_rd), .sd_busy(sd_busy),
        .cart_is_7800(cart_is_7800), .hdr_size(hdr_size), .cart_flags(cart_flags),
        .cart_region(cart_region), .cart_save(cart_save), .cart_xm(cart_xm),
        .cart_size(cart_size), .cart_loaded(cart_loaded)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM model: busy for busy_len cycles after each write (0 = random 1..3).
    int busy_len = 0;
    int busy_cnt = 0;
    always @(posedge clk_sys) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (sd_wr) busy_cnt <= (busy_len == 0) ? int'($urandom_range(3, 1)) : busy_len;
    end
    assign sd_busy = (busy_cnt != 0);

    int n_chk = 0;
    int n_pass = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  file_q[$];
    bit exp_a78, wait_chk, hdr_bad, rise_bad;
    logic wait_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk_sys) begin
        if (reset_n && sd_wr) begin
            chk("wr_while_busy", 32'(sd_busy), 32'd0);
            if (wait_chk) chk("wr_wait_high", 32'(ioctl_wait), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'(sd_addr), 32'hFFFFFFFF);
            end else begin
                chk("wr_addr", 32'(sd_addr), 32'(exp_q[0][32:8]));
                chk("wr_data", 32'(sd_din), 32'(exp_q[0][7:0]));
                void'(exp_q.pop_front());
            end
        end
        if (reset_n && wait_prev && !ioctl_wait) chk("wait_fall_busy", 32'(sd_busy), 32'd0);
        wait_prev <= ioctl_wait;
    end

    task automatic check_reset(input string tag);
        chk({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
        chk({tag, "_sd_wr"}, 32'(sd_wr), 32'd0);
        chk({tag, "_sd_rd"}, 32'(sd_rd), 32'd0);
        chk({tag, "_sd_addr"}, 32'(sd_addr), 32'd0);
        chk({tag, "_sd_din"}, 32'(sd_din), 32'd0);
        chk({tag, "_is7800"}, 32'(cart_is_7800), 32'd0);
        chk({tag, "_hdr_size"}, hdr_size, 32'h00008000);
        chk({tag, "_flags"}, 32'(cart_flags), 32'd0);
        chk({tag, "_region_save_xm"}, {8'd0, cart_region, cart_save, cart_xm}, 32'd0);
        chk({tag, "_size"}, cart_size, 32'd0);
        chk({tag, "_loaded"}, 32'(cart_loaded), 32'd0);
    endtask

    task automatic make_a78(input int payload, input bit rnd);
        file_q.delete();
        for (int i = 0; i < 128; i++) file_q.push_back(rnd ? 8'($urandom) : 8'h00);
        file_q[0] = 8'h01; file_q[1] = 8'h41; file_q[2] = 8'h54; file_q[3] = 8'h41;
        file_q[4] = 8'h52; file_q[5] = 8'h49; file_q[6] = 8'h37; file_q[7] = 8'h38;
        file_q[8] = 8'h30; file_q[9] = 8'h30;
        if (!rnd) begin
            file_q[51] = 8'hC0; file_q[54] = 8'h01; file_q[57] = 8'h01; file_q[58] = 8'h01;
        end
        for (int i = 0; i < payload; i++) file_q.push_back(8'($urandom));
    endtask

    task automatic make_a26(input int len);
        file_q.delete();
        for (int i = 0; i < len; i++) file_q.push_back(8'($urandom));
        if (len > 1) file_q[1] = 8'h00;
    endtask

    task automatic wait_low();
        int t = 0;
        while (ioctl_wait && t < 200) begin @(negedge clk_sys); t++; end
        if (ioctl_wait) begin
            n_chk++;
            $display("FAIL wait_timeout: ioctl_wait still 1 after %0d cycles", t);
        end
    endtask

    task automatic send_byte(input int a, input logic [7:0] d, input bit hb, input bit sb);
        wait_low();
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
        if (hb && ioctl_wait) hdr_bad = 1'b1;
        if (sb && !ioctl_wait) rise_bad = 1'b1;
    endtask

    task automatic run_load(input int abort_at, input int inject_at, input int rdprobe_at);
        int n = file_q.size();
        logic [31:0] e_size, e_hsize;
        exp_a78 = (n >= 6) && file_q[1] == 8'h41 && file_q[2] == 8'h54 &&
                  file_q[3] == 8'h41 && file_q[4] == 8'h52 && file_q[5] == 8'h49;
        for (int i = 0; i < n; i++) begin
            if (!exp_a78) exp_q.push_back({25'(i), file_q[i]});
            else if (i >= 128) exp_q.push_back({25'(i - 128), file_q[i]});
        end
        hdr_bad = 1'b0;
        rise_bad = 1'b0;
        @(negedge clk_sys);
        ioctl_index = 8'h01;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < n; i++) begin
            send_byte(i, file_q[i], (i < 5) || (exp_a78 && i < 128),
                      exp_a78 ? (i >= 128) : (i >= 5));
            if (i == inject_at) begin
                ioctl_addr = 25'h1FFF0;
                ioctl_dout = 8'hEE;
                ioctl_wr = 1'b1;
                @(negedge clk_sys);
                ioctl_wr = 1'b0;
            end
            if (i == rdprobe_at) begin
                core_addr = 25'h1234;
                core_rd = 1'b1;
                #1;
                chk("rd_blocked_stream", 32'(sd_rd), 32'd0);
                core_rd = 1'b0;
                core_addr = '0;
            end
            if (i == abort_at) begin
                #2 reset_n = 1'b0;
                #1 check_reset("midreset");
                ioctl_download = 1'b0;
                repeat (4) @(negedge clk_sys);
                reset_n = 1'b1;
                exp_q.delete();
                @(negedge clk_sys);
                return;
            end
        end
        wait_low();
        ioctl_download = 1'b0;
        repeat (60) @(negedge clk_sys);
        e_size  = (n == 0) ? 32'd0 : (exp_a78 ? 32'(n - 128) : 32'(n));
        e_hsize = exp_a78 ? {file_q[49], file_q[50], file_q[51], file_q[52]} : 32'h00008000;
        chk("writes_pending", 32'(exp_q.size()), 32'd0);
        chk("cart_size", cart_size, e_size);
        chk("cart_is_7800", 32'(cart_is_7800), 32'(exp_a78));
        chk("hdr_size", hdr_size, e_hsize);
        chk("cart_flags", 32'(cart_flags), exp_a78 ? {16'd0, file_q[53], file_q[54]} : 32'd0);
        chk("region_save_xm", {8'd0, cart_region, cart_save, cart_xm},
            exp_a78 ? {8'd0, file_q[57], file_q[58], file_q[63]} : 32'd0);
        chk("cart_loaded", 32'(cart_loaded), 32'd1);
        chk("hdr_no_wait", 32'(hdr_bad), 32'd0);
        chk("stream_wait_rise", 32'(rise_bad), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        check_reset("reset");
        reset_n = 1'b1;
        @(negedge clk_sys);

        core_addr = 25'h1234;
        core_rd = 1'b1;
        #1;
        chk("rd_pass_sd_rd", 32'(sd_rd), 32'd1);
        chk("rd_pass_sd_addr", 32'(sd_addr), 32'h1234);
        core_rd = 1'b0;
        core_addr = '0;

        wait_chk = 1'b1;
        make_a78(2048, 1'b0);
        run_load(-1, -1, -1);

        make_a26(4096);
        file_q[0] = 8'h78; file_q[1] = 8'hD8; file_q[2] = 8'hA2;
        file_q[3] = 8'hFF; file_q[4] = 8'h9A; file_q[5] = 8'hE8;
        run_load(-1, -1, -1);

        wait_chk = 1'b0;
        make_a26(3);
        run_load(-1, -1, -1);

        wait_chk = 1'b1;
        busy_len = 10;
        make_a26(40);
        run_load(-1, 20, 25);
        busy_len = 0;

        make_a78(400, 1'b1);
        run_load(300, -1, -1);

        make_a78(512, 1'b1);
        run_load(-1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
